// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: FSM encoding, frame layout and frame validity check.
package ps2_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  localparam int   PS2_FRAME_BITS = 11;
  localparam logic PS2_START_BIT  = 1'b0;
  localparam logic PS2_STOP_BIT   = 1'b1;

  // bits[7:0] data, bits[8] parity, bits[9] stop; odd parity over data+parity.
  function automatic logic frame_ok(input logic [9:0] bits);
    return (^bits[8:0]) && (bits[9] == PS2_STOP_BIT);
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous FIFO with a registered head output that holds its last value when empty.
module ps2_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      count;
  logic [AW-1:0]    rd_nxt;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign do_push = push && (!full || do_pop);
  assign count   = wr_q - rd_q;
  assign rd_nxt  = rd_q[AW-1:0] + 1'b1;
  assign dout    = dout_q;

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    dout_d = dout_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
      if (count == (AW+1)'(1)) begin
        if (do_push) dout_d = din;
      end else begin
        dout_d = mem_q[rd_nxt];
      end
    end else if (empty && do_push) begin
      dout_d = din;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      dout_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      dout_q <= dout_d;
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes the raw lines, deframes 11-bit frames
// with odd parity and a mid-frame timeout, and queues accepted scancodes in a FIFO.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       ready,
  output logic [7:0] data,
  output logic       valid,
  output logic       overflow,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]    clk_sync_q;
  logic [1:0]    dat_sync_q;
  logic [1:0]    state_q, state_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [9:0]    shreg_q, shreg_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ferr_q, ferr_d;
  logic          ovf_q, ovf_d;
  logic          fall, sbit;
  logic          push, pop, empty, full;

  assign fall      = clk_sync_q[2] & ~clk_sync_q[1];
  assign sbit      = dat_sync_q[1];
  assign valid     = !empty;
  assign pop       = ready && valid;
  assign overflow  = ovf_q;
  assign frame_err = ferr_q;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    tmo_d    = tmo_q;
    ferr_d   = 1'b0;
    push     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        bitcnt_d = '0;
        tmo_d    = '0;
        if (fall && sbit == PS2_START_BIT) state_d = ST_RECV;
      end
      ST_RECV: begin
        if (fall) begin
          shreg_d  = {sbit, shreg_q[9:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          tmo_d    = '0;
          if (bitcnt_q == 4'(PS2_FRAME_BITS - 2)) state_d = ST_CHECK;
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d  = ST_IDLE;
          bitcnt_d = '0;
          tmo_d    = '0;
          ferr_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_CHECK: begin
        state_d  = ST_IDLE;
        bitcnt_d = '0;
        if (frame_ok(shreg_q)) push   = 1'b1;
        else                   ferr_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Overflow means a byte was lost: FIFO full and no pop freeing a slot this cycle.
  assign ovf_d = ovf_q | (push & full & ~pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      state_q    <= ST_IDLE;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      tmo_q      <= '0;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      tmo_q      <= tmo_d;
      ferr_q     <= ferr_d;
      ovf_q      <= ovf_d;
    end
  end

  ps2_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .din  (shreg_q[7:0]),
    .pop  (pop),
    .dout (data),
    .empty(empty),
    .full (full)
  );

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: framing, parity, FIFO fill/drain/overflow, timeout and reset.
module tb_ps2_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       overflow;
  logic       frame_err;

  int   errors = 0;
  int   checks = 0;
  int   ferr_total = 0;
  int   f0;
  logic lowv [10];
  logic [7:0] seq [9];

  always #5 clk = ~clk;

  ps2_rx #(
    .FIFO_DEPTH (8),
    .TIMEOUT_CYC(5000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ready    (ready),
    .data     (data),
    .valid    (valid),
    .overflow (overflow),
    .frame_err(frame_err)
  );

  always @(negedge clk) if (frame_err) ferr_total <= ferr_total + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One PS/2 bit; valid is recorded each cycle of the low phase. With pop_chk the
  // consumer asserts ready only during the CHECK cycle (3rd negedge after the drop).
  task automatic send_bit(input logic b, input logic pop_chk);
    ps2_data = b;
    wait_neg(10);
    ps2_clk = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lowv[i] = valid;
      if (pop_chk && i == 2) ready = 1'b1;
      if (pop_chk && i == 3) ready = 1'b0;
    end
    ps2_clk = 1'b1;
    wait_neg(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits,
                            input logic pop_chk);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i], pop_chk && (i == 10));
    ps2_data = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wait_neg(3);
    rst_n = 1'b1;
    wait_neg(5);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; ready = 1'b0;
    wait_neg(3);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    rst_n = 1'b1;
    wait_neg(5);
  endtask

  task automatic test_single();
    f0 = ferr_total;
    send_frame(8'h1C, 1'b0, 11, 1'b0);
    checks++; if (lowv[2] !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", lowv[2]); end
    checks++; if (lowv[3] !== 1'b1) begin errors++; $display("FAIL single_latency_valid: got %b want 1", lowv[3]); end
    checks++; if (data !== 8'h1C) begin errors++; $display("FAIL single_data: got %h want 1c", data); end
    checks++; if (ferr_total - f0 !== 0) begin errors++; $display("FAIL single_no_ferr: got %0d want 0", ferr_total - f0); end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %b want 0", valid); end
    checks++; if (data !== 8'h1C) begin errors++; $display("FAIL single_stale_data: got %h want 1c", data); end
  endtask

  task automatic test_parity_err();
    f0 = ferr_total;
    send_frame(8'h1C, 1'b1, 11, 1'b0);
    wait_neg(2);
    checks++; if (ferr_total - f0 !== 1) begin errors++; $display("FAIL parity_ferr_pulses: got %0d want 1", ferr_total - f0); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL parity_valid: got %b want 0", valid); end
  endtask

  task automatic drain(input int first, input int n, input string tag);
    ready = 1'b1;
    for (int i = first; i < first + n; i++) begin
      checks++;
      if (valid !== 1'b1 || data !== seq[i]) begin
        errors++; $display("FAIL %s_drain%0d: got valid=%b data=%h want valid=1 data=%h", tag, i, valid, data, seq[i]);
      end
      @(negedge clk);
    end
    ready = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL %s_empty: got valid=%b want 0", tag, valid); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) send_frame(seq[i], 1'b0, 11, 1'b0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_at_eight: got %b want 0", overflow); end
    send_frame(seq[8], 1'b0, 11, 1'b0);
    wait_neg(2);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
    drain(0, 8, "ovf");
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_full_pop();
    do_reset();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf_cleared: got %b want 0", overflow); end
    for (int i = 0; i < 8; i++) send_frame(seq[i], 1'b0, 11, 1'b0);
    send_frame(seq[8], 1'b0, 11, 1'b1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf: got %b want 0", overflow); end
    drain(1, 8, "fullpop");
  endtask

  task automatic test_timeout();
    f0 = ferr_total;
    send_frame(8'h1C, 1'b0, 4, 1'b0);
    wait_neg(4800);
    checks++; if (ferr_total - f0 !== 0) begin errors++; $display("FAIL timeout_early: got %0d pulses want 0", ferr_total - f0); end
    for (int k = 0; k < 400 && ferr_total == f0; k++) @(negedge clk);
    wait_neg(2);
    checks++; if (ferr_total - f0 !== 1) begin errors++; $display("FAIL timeout_pulse: got %0d pulses want 1", ferr_total - f0); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL timeout_valid: got %b want 0", valid); end
    wait_neg(20);
    f0 = ferr_total;
    send_frame(8'h1C, 1'b0, 11, 1'b0);
    checks++; if (lowv[3] !== 1'b1 || data !== 8'h1C) begin
      errors++; $display("FAIL timeout_next_frame: got valid=%b data=%h want valid=1 data=1c", lowv[3], data);
    end
    checks++; if (ferr_total - f0 !== 0) begin errors++; $display("FAIL timeout_next_ferr: got %0d want 0", ferr_total - f0); end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) send_frame(seq[i], 1'b0, 11, 1'b0);
    checks++; if (valid !== 1'b1 || data !== 8'hF0) begin
      errors++; $display("FAIL rstmid_queued: got valid=%b data=%h want valid=1 data=f0", valid, data);
    end
    send_frame(8'h1C, 1'b0, 5, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h want 00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", valid); end
    checks++; if (overflow !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL rstmid_flags: got ovf=%b ferr=%b want 0 0", overflow, frame_err);
    end
    wait_neg(3);
    rst_n = 1'b1;
    wait_neg(5);
    f0 = ferr_total;
    send_frame(8'h1C, 1'b0, 11, 1'b0);
    checks++; if (lowv[2] !== 1'b0 || lowv[3] !== 1'b1) begin
      errors++; $display("FAIL rstmid_latency: got %b%b want 01", lowv[2], lowv[3]);
    end
    checks++; if (data !== 8'h1C) begin errors++; $display("FAIL rstmid_data_after: got %h want 1c", data); end
    checks++; if (ferr_total - f0 !== 0) begin errors++; $display("FAIL rstmid_ferr: got %0d want 0", ferr_total - f0); end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rstmid_single_entry: got %b want 0", valid); end
  endtask

  initial begin
    seq[0] = 8'hF0; seq[1] = 8'h1C; seq[2] = 8'h32; seq[3] = 8'h21; seq[4] = 8'h23;
    seq[5] = 8'h2B; seq[6] = 8'h34; seq[7] = 8'h33; seq[8] = 8'h5A;
    test_reset();
    test_single();
    test_parity_err();
    test_overflow();
    test_full_pop();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: receive FIFO entries, power of two, minimum 2.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 5000: idle clk cycles mid-frame before the frame is abandoned.
REQ-003 SHALL have port clk  input  1  the single system clock; all logic runs on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
REQ-007 SHALL have port ready  input  1  consumer pops the head byte when ready && valid.
REQ-008 SHALL have port data  output  8  FIFO head scancode, fed to the downstream scancode lookup mux.
REQ-009 SHALL have port valid  output  1  FIFO non-empty.
REQ-010 SHALL have port overflow  output  1  sticky: a received byte was dropped because the FIFO was full.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse: a frame was discarded.

Function
REQ-012 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers; the falling-edge event (fall) SHALL be derived from a third ps2_clk flop.
REQ-013 SHALL sample the synchronized ps2_data on each fall cycle only.
REQ-014 SHALL run FSM IDLE -> RECV -> CHECK -> IDLE; IDLE->RECV on a fall with sampled data 0 (start bit); a fall with data 1 in IDLE SHALL be ignored.
REQ-015 SHALL, in RECV, shift 8 data bits LSB-first, then the parity bit, then the stop bit, tracked by a 4-bit counter; after the stop-bit fall it SHALL enter CHECK.
REQ-016 SHALL, in CHECK (one cycle), accept the frame iff the XOR of 8 data bits and parity is 1 (odd parity) and stop is 1; otherwise pulse frame_err and discard.
REQ-017 SHALL push an accepted byte in the CHECK cycle; valid SHALL be high the next cycle (total latency: 2 clk after the stop-bit fall).
REQ-018 SHALL, in RECV, count clk cycles since the last fall; at TIMEOUT_CYC, return to IDLE, pulse frame_err, and discard partial bits.
REQ-019 SHALL pop on ready && valid; data SHALL show the new head (or hold stale, with valid low when empty) the next cycle.
REQ-020 SHALL, when full, push successfully if a pop occurs in the same cycle; otherwise drop the byte and set overflow.
REQ-021 SHALL, on simultaneous push and pop when empty, push only (nothing to pop); valid rises next cycle.
REQ-022 SHALL wrap read/write pointers modulo FIFO_DEPTH, using an extra MSB to distinguish full from empty.
REQ-023 SHALL not assert ready-dependent combinational paths to ps2 inputs; data and valid SHALL be registered-state outputs.

Reset
REQ-024 SHALL, on rst_n low, asynchronously clear: FSM to IDLE, counters 0, synchronizers to 1 (line idle), FIFO pointers 0, data 0x00, valid 0, overflow 0, frame_err 0.
REQ-025 SHALL, on reset mid-frame, discard the partial frame; after release, reception resumes only on a new start bit.
REQ-026 SHALL clear overflow only by reset.

Structure
REQ-027 SHALL place the FSM state encoding, PS2_FRAME_BITS=11 and the start/stop bit values in shared package ps2_pkg.
REQ-028 SHALL implement the FIFO as sub-module ps2_fifo (params WIDTH, DEPTH; ports push, din, pop, dout, empty, full).
REQ-029 SHALL keep the receiver FSM, synchronizers and timeout counter in ps2_rx itself.

Verification
REQ-030 SHALL check: frame for 0x1C (bits 0,0,0,1,1,1,0,0,0,0,1: start, LSB-first data, parity 0, stop) -> valid high 2 clk after the last fall, data=0x1C.
REQ-031 SHALL check: 0x1C frame with parity 1 -> one frame_err pulse, valid stays 0.
REQ-032 SHALL check: 9 frames (0xF0,0x1C,...) with ready=0, depth 8 -> 8 bytes held in order, overflow=1; then ready=1 drains 0xF0 first.
REQ-033 SHALL check: full FIFO with ready=1 during the 9th CHECK cycle -> no overflow, 9th byte stored.
REQ-034 SHALL check: 4 bits of a frame then no ps2_clk for 5000 clk -> frame_err pulse, FSM IDLE; next full 0x1C frame is received correctly.
REQ-035 SHALL check: rst_n asserted mid-frame and after 3 queued bytes -> all outputs 0 immediately; the subsequent frame is received cleanly.
